// File: rtl/mem_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_buf
// Description : EX/MEM stage register that issues the memory request itself,
//               builds store strobes and drops responses of flushed loads and
//               stores. Optional define MEM_RDATA_BYPASS_EN forwards mem_rdata
//               to write-back in the cycle it arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_buf #(
    parameter int DATA_WIDTH      = 32,
    parameter int RD_WIDTH        = 5,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    hold,
    input  logic                    valid_ex,
    input  logic                    ready_go_ex,
    output logic                    allow_in_mem,
    input  logic [DATA_WIDTH-1:0]   mem_addr_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    input  logic [3:0]              control_flow_ex,
    input  logic [RD_WIDTH-1:0]     rd_ex,
    input  logic [2:0]              ins_func3_i,
    input  logic                    fence_type_ex,
    output logic                    mem_req,
    output logic                    mem_wr,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_addr_ok,
    input  logic                    mem_data_ok,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    valid_mem,
    output logic                    ready_go_mem,
    input  logic                    allow_in_wb,
    output logic [DATA_WIDTH-1:0]   mem_read_data_o,
    output logic [RD_WIDTH-1:0]     rd_mem,
    output logic [2:0]              ins_func3_o,
    output logic [1:0]              control_flow_mem,
    output logic                    fence_type_mem
);

    localparam int c_STRB_W = DATA_WIDTH / 8;
    localparam int c_OFF_W  = $clog2(c_STRB_W);
    localparam int c_CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_OUT = c_CNT_W'(MAX_OUTSTANDING);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nx;
    logic [c_CNT_W-1:0]    r_drop_cnt;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_cf;
    logic [RD_WIDTH-1:0]   r_rd;
    logic [2:0]            r_func3;
    logic                  r_fence;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_capture;
    logic [1:0]            w_entry;
    logic                  w_mem_req;
    logic                  w_accept;
    logic                  w_data_live;
    logic                  w_drop_inc;
    logic                  w_drop_dec;
    logic                  w_ready_go;
    logic                  w_wb_take;
    logic [c_OFF_W-1:0]    w_off;
    logic [c_STRB_W-1:0]   w_size_mask;

    assign allow_in_mem = (r_state == c_ST_IDLE)
                        | ((r_state == c_ST_DONE) & allow_in_wb & ~hold);
    assign w_capture    = valid_ex & ready_go_ex & allow_in_mem & ~flush;
    assign w_entry      = (control_flow_ex[3] | control_flow_ex[2]) ? c_ST_REQ : c_ST_DONE;

    // In REQ nothing live is outstanding, so only dropped requests count.
    assign w_mem_req   = (r_state == c_ST_REQ) & (r_drop_cnt < c_MAX_OUT);
    assign w_accept    = w_mem_req & mem_addr_ok;
    assign w_data_live = (r_state == c_ST_WAIT) & mem_data_ok & (r_drop_cnt == '0);
    assign w_drop_inc  = flush & (((r_state == c_ST_WAIT) & ~w_data_live) | w_accept);
    assign w_drop_dec  = mem_data_ok & (r_drop_cnt != '0);

`ifdef MEM_RDATA_BYPASS_EN
    assign w_ready_go      = (r_state == c_ST_DONE) | w_data_live;
    assign mem_read_data_o = w_data_live ? mem_rdata : r_rdata;
`else
    assign w_ready_go      = (r_state == c_ST_DONE);
    assign mem_read_data_o = r_rdata;
`endif
    assign w_wb_take = w_ready_go & allow_in_wb & ~hold;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_ST_IDLE: if (w_capture) w_state_nx = w_entry;
            c_ST_REQ: begin
                if (flush)         w_state_nx = c_ST_IDLE;
                else if (w_accept) w_state_nx = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (flush)            w_state_nx = c_ST_IDLE;
                else if (w_data_live) w_state_nx = w_wb_take ? c_ST_IDLE : c_ST_DONE;
            end
            c_ST_DONE: begin
                if (flush)          w_state_nx = c_ST_IDLE;
                else if (w_wb_take) w_state_nx = w_capture ? w_entry : c_ST_IDLE;
            end
            default: w_state_nx = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_valid    <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_nx;
            r_valid <= (w_state_nx != c_ST_IDLE);
            if (w_drop_inc & ~w_drop_dec)
                r_drop_cnt <= r_drop_cnt + 1'b1;
            else if (w_drop_dec & ~w_drop_inc)
                r_drop_cnt <= r_drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_cf    <= '0;
            r_rd    <= '0;
            r_func3 <= '0;
            r_fence <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_capture) begin
                r_addr  <= mem_addr_i;
                r_wdata <= mem_wdata_i;
                r_cf    <= control_flow_ex;
                r_rd    <= rd_ex;
                r_func3 <= ins_func3_i;
                r_fence <= fence_type_ex;
            end
            if (w_data_live & r_cf[3])
                r_rdata <= mem_rdata;
        end
    end

    // Access size from func3[1:0]; doubleword only exists on a 64-bit bus.
    always_comb begin
        w_size_mask = '0;
        case (r_func3[1:0])
            2'd0:    w_size_mask = c_STRB_W'(1);
            2'd1:    w_size_mask = c_STRB_W'(3);
            2'd2:    w_size_mask = c_STRB_W'(15);
            default: w_size_mask = (DATA_WIDTH == 64) ? '1 : '0;
        endcase
    end

    assign w_off     = r_addr[c_OFF_W-1:0];
    assign mem_req   = w_mem_req;
    assign mem_wr    = w_mem_req & r_cf[2];
    assign mem_addr  = r_addr;
    assign mem_wstrb = r_cf[2] ? (w_size_mask << w_off) : '0;
    assign mem_wdata = r_wdata << {w_off, 3'b000};

    assign valid_mem        = r_valid;
    assign ready_go_mem     = w_ready_go;
    assign rd_mem           = r_rd;
    assign ins_func3_o      = r_func3;
    assign control_flow_mem = r_valid ? r_cf[1:0] : 2'b00;
    assign fence_type_mem   = r_valid & r_fence;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_buf
// Description : Self-checking bench for mem_stage_buf: directed scenarios plus
//               a randomized run against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_buf;

    localparam int DW   = 32;
    localparam int RDW  = 5;
    localparam int MAXO = 2;
    localparam int SW   = DW / 8;
`ifdef MEM_RDATA_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [3:0]    cf;
        logic [RDW-1:0] rd;
        logic [2:0]    f3;
        logic          fence;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
    } inst_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic flush = 0, hold = 0, valid_ex = 0, ready_go_ex = 0, allow_in_wb = 0;
    logic [DW-1:0] mem_addr_i = '0, mem_wdata_i = '0, mem_rdata = '0;
    logic [3:0] control_flow_ex = '0;
    logic [RDW-1:0] rd_ex = '0;
    logic [2:0] ins_func3_i = '0;
    logic fence_type_ex = 0, mem_addr_ok = 0, mem_data_ok = 0;
    logic allow_in_mem, mem_req, mem_wr, valid_mem, ready_go_mem, fence_type_mem;
    logic [DW-1:0] mem_addr, mem_wdata, mem_read_data_o;
    logic [SW-1:0] mem_wstrb;
    logic [RDW-1:0] rd_mem;
    logic [2:0] ins_func3_o;
    logic [1:0] control_flow_mem;

    int errs = 0;
    int checks = 0;

    mem_stage_buf #(.DATA_WIDTH(DW), .RD_WIDTH(RDW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
        .valid_ex(valid_ex), .ready_go_ex(ready_go_ex), .allow_in_mem(allow_in_mem),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .control_flow_ex(control_flow_ex),
        .rd_ex(rd_ex), .ins_func3_i(ins_func3_i), .fence_type_ex(fence_type_ex),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .valid_mem(valid_mem), .ready_go_mem(ready_go_mem),
        .allow_in_wb(allow_in_wb), .mem_read_data_o(mem_read_data_o), .rd_mem(rd_mem),
        .ins_func3_o(ins_func3_o), .control_flow_mem(control_flow_mem),
        .fence_type_mem(fence_type_mem)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] cf, input logic [RDW-1:0] rd, input logic [2:0] f3,
                           input logic [DW-1:0] addr, input logic [DW-1:0] wd);
        valid_ex = 1; ready_go_ex = 1; control_flow_ex = cf; rd_ex = rd;
        ins_func3_i = f3; mem_addr_i = addr; mem_wdata_i = wd; fence_type_ex = 0;
    endtask

    function automatic logic [SW-1:0] exp_strb(input inst_t i);
        int off = int'(i.addr % SW);
        int nbytes = 1 << i.f3[1:0];
        int m;
        if (!i.cf[2] || nbytes > SW) return '0;
        m = ((1 << nbytes) - 1) << off;
        return m[SW-1:0];
    endfunction

    function automatic logic [DW-1:0] exp_wdata(input inst_t i);
        logic [2*DW-1:0] t;
        t = {{DW{1'b0}}, i.wdata} << (8 * (i.addr % SW));
        return t[DW-1:0];
    endfunction

    task automatic test_reset;
        rst_n = 0;
        #2;
        checks++; if ({valid_mem, ready_go_mem, mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb, mem_read_data_o,
                       rd_mem, ins_func3_o, control_flow_mem, fence_type_mem} !== '0) begin
            errs++; $display("FAIL reset_outputs: some output nonzero, req=%b valid=%b addr=%h", mem_req, valid_mem, mem_addr); end
        checks++; if (allow_in_mem !== 1'b1) begin errs++; $display("FAIL reset_allow_in: got %b want 1", allow_in_mem); end
        tick; tick;
        rst_n = 1;
        tick;
    endtask

    task automatic test_alu;
        present(4'b0010, 5'd5, 3'd0, 32'h55, 32'h0);
        fence_type_ex = 1; allow_in_wb = 1;
        tick;
        valid_ex = 0;
        checks++; if (valid_mem !== 1'b1) begin errs++; $display("FAIL alu_valid: got %b want 1", valid_mem); end
        checks++; if (rd_mem !== 5'd5) begin errs++; $display("FAIL alu_rd: got %0d want 5", rd_mem); end
        checks++; if (ready_go_mem !== 1'b1) begin errs++; $display("FAIL alu_ready_go: got %b want 1", ready_go_mem); end
        checks++; if (mem_req !== 1'b0) begin errs++; $display("FAIL alu_no_req: got %b want 0", mem_req); end
        checks++; if ({control_flow_mem, fence_type_mem} !== 3'b101) begin errs++; $display("FAIL alu_cf_fence: got %b want 101", {control_flow_mem, fence_type_mem}); end
        tick;
        checks++; if (valid_mem !== 1'b0) begin errs++; $display("FAIL alu_retired: got %b want 0", valid_mem); end
        allow_in_wb = 0;
    endtask

    task automatic test_store;
        present(4'b0100, 5'd0, 3'd0, 32'h1003, 32'h0000_00AB);
        tick;
        valid_ex = 0;
        checks++; if ({mem_req, mem_wr} !== 2'b11) begin errs++; $display("FAIL sb_req_wr: got %b want 11", {mem_req, mem_wr}); end
        checks++; if (mem_wstrb !== 4'b1000) begin errs++; $display("FAIL sb_wstrb: got %b want 1000", mem_wstrb); end
        checks++; if (mem_wdata !== 32'hAB00_0000) begin errs++; $display("FAIL sb_wdata: got %h want ab000000", mem_wdata); end
        checks++; if (mem_addr !== 32'h1003) begin errs++; $display("FAIL sb_addr: got %h want 1003", mem_addr); end
        mem_addr_ok = 1; tick; mem_addr_ok = 0;
        checks++; if (mem_req !== 1'b0) begin errs++; $display("FAIL sb_req_dropped: got %b want 0", mem_req); end
        mem_data_ok = 1; tick; mem_data_ok = 0;
        checks++; if (ready_go_mem !== 1'b1) begin errs++; $display("FAIL sb_done: got %b want 1", ready_go_mem); end
        allow_in_wb = 1; tick; allow_in_wb = 0;
    endtask

    task automatic test_flush_req;
        present(4'b0100, 5'd1, 3'd2, 32'h2000, 32'h1234_5678);
        tick;
        valid_ex = 0;
        checks++; if ({mem_req, mem_wstrb} !== 5'b1_1111) begin errs++; $display("FAIL sw_req_strb: got %b want 11111", {mem_req, mem_wstrb}); end
        flush = 1; tick; flush = 0;
        checks++; if ({mem_req, valid_mem, allow_in_mem} !== 3'b001) begin errs++; $display("FAIL flush_req_withdraw: got %b want 001", {mem_req, valid_mem, allow_in_mem}); end
    endtask

    task automatic test_load;
        present(4'b1000, 5'd7, 3'd2, 32'h1000, 32'h0);
        tick;
        valid_ex = 0;
        checks++; if ({mem_req, mem_wr, mem_wstrb} !== 6'b10_0000) begin errs++; $display("FAIL lw_req: got %b want 100000", {mem_req, mem_wr, mem_wstrb}); end
        checks++; if (mem_addr !== 32'h1000) begin errs++; $display("FAIL lw_addr: got %h want 1000", mem_addr); end
        mem_addr_ok = 1; tick; mem_addr_ok = 0;
        checks++; if ({mem_req, ready_go_mem} !== 2'b00) begin errs++; $display("FAIL lw_wait: got %b want 00", {mem_req, ready_go_mem}); end
        mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (ready_go_mem !== BYP) begin errs++; $display("FAIL lw_bypass_ready: got %b want %b", ready_go_mem, BYP); end
        tick; mem_data_ok = 0; mem_rdata = '0;
        checks++; if ({valid_mem, ready_go_mem} !== 2'b11) begin errs++; $display("FAIL lw_done: got %b want 11", {valid_mem, ready_go_mem}); end
        checks++; if (mem_read_data_o !== 32'hDEAD_BEEF) begin errs++; $display("FAIL lw_data: got %h want deadbeef", mem_read_data_o); end
        checks++; if (rd_mem !== 5'd7) begin errs++; $display("FAIL lw_rd: got %0d want 7", rd_mem); end
        allow_in_wb = 1; tick; allow_in_wb = 0;
        checks++; if (valid_mem !== 1'b0) begin errs++; $display("FAIL lw_retired: got %b want 0", valid_mem); end
    endtask

    task automatic test_flush_wait;
        present(4'b1000, 5'd2, 3'd2, 32'h3000, 32'h0);
        tick; valid_ex = 0;
        mem_addr_ok = 1; tick; mem_addr_ok = 0;
        flush = 1; tick; flush = 0;
        checks++; if (valid_mem !== 1'b0) begin errs++; $display("FAIL fw_flushed: got %b want 0", valid_mem); end
        present(4'b1000, 5'd3, 3'd2, 32'h3004, 32'h0);
        tick; valid_ex = 0;
        checks++; if (mem_req !== 1'b1) begin errs++; $display("FAIL fw_second_req: got %b want 1", mem_req); end
        mem_addr_ok = 1; tick; mem_addr_ok = 0;
        flush = 1; tick; flush = 0;
        present(4'b1000, 5'd9, 3'd2, 32'h3008, 32'h0);
        tick; valid_ex = 0;
        checks++; if (mem_req !== 1'b0) begin errs++; $display("FAIL fw_limit_blocks_req: got %b want 0", mem_req); end
        mem_data_ok = 1; mem_rdata = 32'h11;
        tick; mem_data_ok = 0;
        checks++; if (mem_req !== 1'b1) begin errs++; $display("FAIL fw_req_after_drain: got %b want 1", mem_req); end
        mem_addr_ok = 1; tick; mem_addr_ok = 0;
        mem_data_ok = 1; mem_rdata = 32'h22;
        #1;
        checks++; if (ready_go_mem !== 1'b0) begin errs++; $display("FAIL fw_drop_not_ready: got %b want 0", ready_go_mem); end
        tick;
        mem_rdata = 32'h33;
        tick; mem_data_ok = 0; mem_rdata = '0;
        checks++; if (ready_go_mem !== 1'b1) begin errs++; $display("FAIL fw_live_done: got %b want 1", ready_go_mem); end
        checks++; if (mem_read_data_o !== 32'h33) begin errs++; $display("FAIL fw_live_data: got %h want 33", mem_read_data_o); end
        checks++; if (rd_mem !== 5'd9) begin errs++; $display("FAIL fw_live_rd: got %0d want 9", rd_mem); end
    endtask

    task automatic test_hold_back_to_back;
        hold = 1; allow_in_wb = 1;
        present(4'b0001, 5'd3, 3'd0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({allow_in_mem, valid_mem} !== 2'b01) begin errs++; $display("FAIL hold_stall: got %b want 01", {allow_in_mem, valid_mem}); end
            checks++; if (mem_read_data_o !== 32'h33) begin errs++; $display("FAIL hold_data_stable: got %h want 33", mem_read_data_o); end
            tick;
        end
        hold = 0;
        #1;
        checks++; if (allow_in_mem !== 1'b1) begin errs++; $display("FAIL hold_release_allow: got %b want 1", allow_in_mem); end
        tick; valid_ex = 0;
        checks++; if ({valid_mem, ready_go_mem, rd_mem} !== {2'b11, 5'd3}) begin errs++; $display("FAIL b2b_capture: got %b/%0d want 11/3", {valid_mem, ready_go_mem}, rd_mem); end
        tick;
        checks++; if (valid_mem !== 1'b0) begin errs++; $display("FAIL b2b_retired: got %b want 0", valid_mem); end
        allow_in_wb = 0;
    endtask

    task automatic test_random;
        bit m_held = 0, m_issued = 0, m_done = 0;
        inst_t m_inst, nx;
        logic [DW-1:0] m_rdata = '0;
        logic [DW-1:0] q_data[$];
        bit q_live[$];
        bit exp_req, live_now, exp_rg, exp_allow, wb_take, ismem, lv;
        int kind;
        m_inst = '{default: '0};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            flush = ($urandom_range(0, 99) < 6);
            hold = ($urandom_range(0, 99) < 20);
            allow_in_wb = ($urandom_range(0, 99) < 75);
            valid_ex = ($urandom_range(0, 99) < 60);
            ready_go_ex = ($urandom_range(0, 99) < 85);
            kind = $urandom_range(0, 2);
            nx.cf = {(kind == 1), (kind == 2), 2'($urandom)};
            nx.rd = RDW'($urandom); nx.f3 = 3'($urandom); nx.fence = 1'($urandom);
            nx.addr = $urandom; nx.wdata = $urandom;
            control_flow_ex = nx.cf; rd_ex = nx.rd; ins_func3_i = nx.f3;
            fence_type_ex = nx.fence; mem_addr_i = nx.addr; mem_wdata_i = nx.wdata;
            mem_addr_ok = ($urandom_range(0, 99) < 50);
            mem_data_ok = (q_data.size() > 0) && ($urandom_range(0, 99) < 45);
            mem_rdata = mem_data_ok ? q_data[0] : $urandom;
            #1;
            exp_req = m_held && (m_inst.cf[3] || m_inst.cf[2]) && !m_issued && (q_data.size() < MAXO);
            live_now = mem_data_ok && q_live[0];
            exp_rg = m_held && (m_done || (BYP && live_now));
            exp_allow = !m_held || (m_done && allow_in_wb && !hold);
            wb_take = !flush && exp_rg && allow_in_wb && !hold;
            checks++; if (valid_mem !== m_held) begin errs++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, valid_mem, m_held); end
            checks++; if (mem_req !== exp_req) begin errs++; $display("FAIL rnd_req c%0d: got %b want %b", cyc, mem_req, exp_req); end
            checks++; if (ready_go_mem !== exp_rg) begin errs++; $display("FAIL rnd_ready_go c%0d: got %b want %b", cyc, ready_go_mem, exp_rg); end
            checks++; if (allow_in_mem !== exp_allow) begin errs++; $display("FAIL rnd_allow_in c%0d: got %b want %b", cyc, allow_in_mem, exp_allow); end
            checks++; if ({control_flow_mem, fence_type_mem} !== (m_held ? {m_inst.cf[1:0], m_inst.fence} : 3'b000)) begin
                errs++; $display("FAIL rnd_cf_fence c%0d: got %b", cyc, {control_flow_mem, fence_type_mem}); end
            if (exp_req) begin
                checks++; if ({mem_addr, mem_wr} !== {m_inst.addr, m_inst.cf[2]}) begin errs++; $display("FAIL rnd_req_addr c%0d: got %h/%b want %h/%b", cyc, mem_addr, mem_wr, m_inst.addr, m_inst.cf[2]); end
                checks++; if (mem_wstrb !== exp_strb(m_inst)) begin errs++; $display("FAIL rnd_wstrb c%0d: got %b want %b", cyc, mem_wstrb, exp_strb(m_inst)); end
                if (m_inst.cf[2]) begin
                    checks++; if (mem_wdata !== exp_wdata(m_inst)) begin errs++; $display("FAIL rnd_wdata c%0d: got %h want %h", cyc, mem_wdata, exp_wdata(m_inst)); end
                end
            end
            if (wb_take) begin
                checks++; if ({rd_mem, ins_func3_o} !== {m_inst.rd, m_inst.f3}) begin errs++; $display("FAIL rnd_wb_fields c%0d: got %0d/%0d want %0d/%0d", cyc, rd_mem, ins_func3_o, m_inst.rd, m_inst.f3); end
                if (m_inst.cf[3]) begin
                    checks++; if (mem_read_data_o !== (m_done ? m_rdata : mem_rdata)) begin errs++; $display("FAIL rnd_wb_load c%0d: got %h want %h", cyc, mem_read_data_o, m_done ? m_rdata : mem_rdata); end
                end
            end
            @(posedge clk);
            if (mem_data_ok) begin
                lv = q_live.pop_front();
                void'(q_data.pop_front());
                if (lv) begin m_done = 1; m_rdata = mem_rdata; end
            end
            if (exp_req && mem_addr_ok) begin
                q_data.push_back($urandom);
                q_live.push_back(!flush);
                m_issued = 1;
            end
            if (flush) begin
                m_held = 0;
                foreach (q_live[i]) q_live[i] = 0;
            end else if (wb_take) begin
                m_held = 0;
            end
            if (valid_ex && ready_go_ex && exp_allow && !flush) begin
                ismem = nx.cf[3] || nx.cf[2];
                m_held = 1; m_inst = nx; m_issued = 0; m_done = !ismem;
            end
            #1;
        end
        valid_ex = 0; flush = 0; hold = 0; mem_addr_ok = 0; mem_data_ok = 0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_flush_req();
        test_load();
        test_flush_wait();
        test_hold_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
